// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: bus geometry, hex glyph table, capture FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

    localparam int SEG_W      = 8;
    localparam int NUM_DIGITS = 8;

    // Active-high a..g patterns (a = MSB) for hex digits 0..F; same table the encoder drives.
    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUBLISH
    } state_t;

endpackage

// File: rtl/seg_capture_decode.sv
// Decodes one active-low segment byte to nibble / dp / blank / err.
// Latency: combinational.
// Backpressure: none.
// Ports: seg (active-low, bit7=a .. bit1=g, bit0=dp) -> nibble, dp, blank, err.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             dp,
    output logic             blank,
    output logic             err
);

    logic [SEG_W-1:0] seg_hi;
    logic [6:0]       seg_ag;

    assign seg_hi = ~seg;
    assign seg_ag = seg_hi[7:1];
    assign dp     = seg_hi[0];

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b1;
        if (seg_ag == 7'b0000000) begin
            blank = 1'b1;
            err   = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg_ag == GLYPH[i]) begin
                    nibble = 4'(i);
                    err    = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Captures a stable 8-digit seven-segment image and publishes the decoded word once per new image.
// Latency: capture at edge T -> o_valid after T+9 (input change to o_valid >= STABLE_CYCLES+9).
// Backpressure: outputs held while o_valid && !i_ready; the input filter keeps running meanwhile.
// Ports: clk, rst (sync, active-high), i_seg0..i_seg7 (active-low), o_value/o_dp/o_blank/o_err,
//        o_valid/i_ready handshake.
module seg_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] i_seg0,
    input  logic [SEG_W-1:0] i_seg1,
    input  logic [SEG_W-1:0] i_seg2,
    input  logic [SEG_W-1:0] i_seg3,
    input  logic [SEG_W-1:0] i_seg4,
    input  logic [SEG_W-1:0] i_seg5,
    input  logic [SEG_W-1:0] i_seg6,
    input  logic [SEG_W-1:0] i_seg7,
    output logic [31:0]      o_value,
    output logic [7:0]       o_dp,
    output logic [7:0]       o_blank,
    output logic [7:0]       o_err,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int         IMG_W      = NUM_DIGITS * SEG_W;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES - 1);

    logic [IMG_W-1:0] seg_in;
    logic [IMG_W-1:0] samp_q;
    logic [IMG_W-1:0] snap_q;
    logic [7:0]       stable_cnt;
    logic             stable;
    logic             published_q;
    logic [2:0]       idx_q;
    state_t           state_q, state_d;

    logic [31:0]      sh_value;
    logic [7:0]       sh_dp, sh_blank, sh_err;

    logic             capture, scan_wr, load_out, accept;

    logic [SEG_W-1:0] dig_seg;
    logic [3:0]       dig_nibble;
    logic             dig_dp, dig_blank, dig_err;

    assign seg_in = {i_seg7, i_seg6, i_seg5, i_seg4, i_seg3, i_seg2, i_seg1, i_seg0};
    assign stable = (stable_cnt == STABLE_MAX);

    // Single decoder shared across digits; the scan walks snap_q so live input changes cannot tear it.
    assign dig_seg = snap_q[{idx_q, 3'b000} +: SEG_W];

    seg_digit_decode u_dec (
        .seg    (dig_seg),
        .nibble (dig_nibble),
        .dp     (dig_dp),
        .blank  (dig_blank),
        .err    (dig_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        scan_wr  = 1'b0;
        load_out = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                // Snapshot comparison suppresses republishing the image already delivered.
                if (stable && (!published_q || samp_q != snap_q)) begin
                    capture = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                scan_wr = 1'b1;
                if (idx_q == 3'd7) state_d = PUBLISH;
            end
            PUBLISH: begin
                // First PUBLISH cycle loads the outputs; afterwards wait for the handshake.
                if (!o_valid) begin
                    load_out = 1'b1;
                end else if (i_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q      <= '0;
            stable_cnt  <= 8'd0;
            snap_q      <= '0;
            published_q <= 1'b0;
            idx_q       <= 3'd0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_err      <= '0;
            o_value     <= '0;
            o_dp        <= '0;
            o_blank     <= '0;
            o_err       <= '0;
            o_valid     <= 1'b0;
        end else begin
            samp_q <= seg_in;
            if (seg_in != samp_q)          stable_cnt <= 8'd0;
            else if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 8'd1;

            if (capture) begin
                snap_q <= samp_q;
                idx_q  <= 3'd0;
            end

            if (scan_wr) begin
                sh_value[{idx_q, 2'b00} +: 4] <= dig_nibble;
                sh_dp[idx_q]                  <= dig_dp;
                sh_blank[idx_q]               <= dig_blank;
                sh_err[idx_q]                 <= dig_err;
                idx_q                         <= idx_q + 3'd1;
            end

            if (load_out) begin
                o_value <= sh_value;
                o_dp    <= sh_dp;
                o_blank <= sh_blank;
                o_err   <= sh_err;
                o_valid <= 1'b1;
            end

            if (accept) begin
                o_valid     <= 1'b0;
                published_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive-side counterpart of the seven-segment encoder block.
- Samples the eight active-low 8-bit segment buses, waits until they are stable, and decodes each digit back to a hex nibble, decimal-point flag, blank flag and error flag.
- Publishes one 32-bit word per distinct stable display image over a valid/ready handshake.
- Used for display loopback checking in the NPC sim environment and for feeding displayed values back to the difftest monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before capture (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- i_seg0 .. i_seg7  in  8 each  active-low segment buses, digit 0 = least significant; bit7=a, bit6=b ... bit1=g, bit0=dp
- o_value  out  32  decoded nibbles; nibble k is digit k, 0 for blank or error digits
- o_dp  out  8  bit k = dp of digit k lit
- o_blank  out  8  bit k = digit k fully dark (a..g off)
- o_err  out  8  bit k = a..g pattern of digit k is neither a hex glyph nor blank
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result

Behaviour:
- Reset: on a clk edge with rst=1, all outputs are 0, the FSM goes to IDLE, stable_cnt=0, and the "published" flag is cleared. rst takes priority in every state, including mid-SCAN and mid-PUBLISH; no partial result is ever presented.
- Input stage:
  - samp_q <= {i_seg7..i_seg0} every cycle.
  - stable_cnt <= 0 if the inputs differ from samp_q; otherwise it increments, saturating at STABLE_CYCLES-1.
  - stable = (stable_cnt == STABLE_CYCLES-1).
- Decode: internally invert to active-high. The a..g to nibble table (bits a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - 0000000 = blank. Any other pattern = err.
  - dp is independent of a..g.
- FSM:
  - IDLE: if stable and (published flag clear or samp_q != snap_q), then snap_q <= samp_q, idx <= 0, go to SCAN.
  - SCAN: one digit per cycle through the single shared decoder; the digit idx result is written into the shadow result registers; idx increments. After idx=7 is written, go to PUBLISH. Input changes during SCAN are ignored, because the scan uses snap_q.
  - PUBLISH:
    - o_value, o_dp, o_blank and o_err are loaded from shadow on entry, with o_valid=1.
    - Outputs are held stable while o_valid=1 and i_ready=0.
    - When o_valid and i_ready are both 1 on an edge: o_valid <= 0, the published flag is set, go to IDLE. The data outputs keep their last values.
- Latency: if capture happens at edge T (IDLE to SCAN), the scan occupies edges T+1..T+8, and o_valid is 1 after edge T+9. With i_ready tied high, o_valid is a single-cycle pulse. The minimum input-change-to-o_valid latency is STABLE_CYCLES+9 cycles.
- An image identical to the last published one is never republished. An image that changes and then returns to the published value is also not republished.
- Glitches shorter than STABLE_CYCLES samples never cause a capture.
- The input stage keeps running during SCAN and PUBLISH. A new image that is already stable when the FSM returns to IDLE is captured on that same IDLE cycle.

Decomposition:
- Package seg_pkg:
  - SEG_W=8, NUM_DIGITS=8.
  - The 16-entry glyph localparam table (active-high a..g), shared with the encoder block.
  - FSM state enum {IDLE, SCAN, PUBLISH}.
- Sub-module seg_digit_decode: combinational. Input 8-bit active-low segment byte; outputs nibble[3:0], dp, blank, err. It is instantiated once and muxed by idx.

Test Plan:
- Reset then hold digits 0..7 with dp off (i_seg0=~8'b11111100, ..., i_seg7=~8'b11100000) and i_ready=1 -> after STABLE_CYCLES+9 cycles: o_valid pulses one cycle with o_value=32'h76543210, o_dp=0, o_blank=0, o_err=0. Holding the same inputs produces no further o_valid.
- Display 0xABCD_EF98 with dp lit on digit 0 and digit 7 -> o_value=32'hABCDEF98, o_dp=8'h81.
- i_seg3=8'hFF (dark), i_seg5=~8'b10010010 (illegal glyph), others show 1 -> o_blank=8'h08, o_err=8'h20, o_value=32'h11010111.
- Toggle i_seg0 between glyph 1 and glyph 2 every 2 cycles for 40 cycles with STABLE_CYCLES=4 -> no o_valid. Then hold glyph 2 -> exactly one o_valid with nibble0=2.
- Hold i_ready=0 for 20 cycles while o_valid=1, and change the inputs to a new stable image meanwhile -> outputs frozen at the old image. Raise i_ready -> handshake, then the new image is captured in the next IDLE cycle and published 9 cycles later.
- Assert rst for one cycle during SCAN (idx=4) -> all outputs 0, no o_valid from the aborted scan. The same image is published afterwards, because the published flag is cleared.
